// File: rtl/zbuf_pkg.sv
// Shared widths, FSM states and the pixel payload for the depth-buffer slice.
package zbuf_pkg;

  localparam int unsigned X_W   = 4;
  localparam int unsigned Y_W   = 4;
  localparam int unsigned Z_W   = 8;
  localparam int unsigned PIX_W = X_W + Y_W + Z_W;
  localparam int unsigned CNT_W = 16;

  // Depth written by a clear sweep: farthest possible value.
  localparam logic [Z_W-1:0] Z_FAR = '1;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    READ,
    CMP
  } state_t;

  // Pixel word as delivered by the arbiter, x in the MSBs.
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [Z_W-1:0] z;
  } pixel_t;

endpackage

// File: rtl/depth_ram.sv
// Simple dual-port depth store: port A read/write for the depth test and
// clear sweep, port B read-only for the display. Reads return old data on
// a same-cycle write to the same address.
module depth_ram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] wdata_a,
  output logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port A, registered reads on both ports (read-before-write).
  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[addr_a] <= wdata_a;
    end
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
  end

endmodule

// File: rtl/z_buffer_unit.sv
// Depth-test unit: accepts one arbitrated pixel at a time, does a
// read-compare-write against the depth RAM, sweeps the RAM to far depth
// after reset or on request, and keeps saturating pass/fail statistics.
module z_buffer_unit
  import zbuf_pkg::*;
#(
  parameter int unsigned X_WIDTH     = X_W,
  parameter int unsigned Y_WIDTH     = Y_W,
  parameter int unsigned Z_WIDTH     = Z_W,
  parameter int unsigned PIXEL_WIDTH = PIX_W,
  parameter int unsigned CNT_WIDTH   = CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_WIDTH-1:0]     pix_in,
  input  logic                       send_z_buffer,
  output logic                       rdy_z_buffer,
  input  logic                       clear_start,
  output logic                       clear_busy,
  output logic                       pass,
  output logic                       fail,
  output logic [CNT_WIDTH-1:0]       pass_cnt,
  output logic [CNT_WIDTH-1:0]       fail_cnt,
  input  logic [X_WIDTH+Y_WIDTH-1:0] disp_addr,
  output logic [Z_WIDTH-1:0]         disp_depth
);

  localparam int unsigned A_WIDTH = X_WIDTH + Y_WIDTH;
  localparam logic [A_WIDTH-1:0] ADDR_LAST = '1;

  state_t               state;
  logic [A_WIDTH-1:0]   clear_addr;
  logic                 clear_pending;
  logic [A_WIDTH-1:0]   pix_addr;
  logic [Z_WIDTH-1:0]   pix_z;

  logic                 transfer_c;
  logic                 closer_c;
  logic                 ram_we_c;
  logic [A_WIDTH-1:0]   ram_addr_c;
  logic [Z_WIDTH-1:0]   ram_wdata_c;
  logic [Z_WIDTH-1:0]   ram_rdata;

  assign transfer_c = send_z_buffer && rdy_z_buffer;
  assign closer_c   = pix_z < ram_rdata;

  // Port A steering: clear sweep, depth-test read, or winning-pixel write.
  always_comb begin
    ram_we_c    = 1'b0;
    ram_addr_c  = pix_addr;
    ram_wdata_c = pix_z;
    case (state)
      CLEAR: begin
        ram_we_c    = !reset;
        ram_addr_c  = clear_addr;
        ram_wdata_c = '1;
      end
      CMP:     ram_we_c = closer_c && !reset;
      default: ;
    endcase
  end

  depth_ram #(
    .ADDR_WIDTH (A_WIDTH),
    .DATA_WIDTH (Z_WIDTH)
  ) u_depth_ram (
    .clk     (clk),
    .we_a    (ram_we_c),
    .addr_a  (ram_addr_c),
    .wdata_a (ram_wdata_c),
    .rdata_a (ram_rdata),
    .addr_b  (disp_addr),
    .rdata_b (disp_depth)
  );

  // Control FSM with registered handshake, status pulses and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= CLEAR;
      clear_addr    <= '0;
      clear_pending <= 1'b0;
      clear_busy    <= 1'b1;
      rdy_z_buffer  <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      pix_addr      <= '0;
      pix_z         <= '0;
    end else begin
      pass <= 1'b0;
      fail <= 1'b0;
      case (state)
        CLEAR: begin
          clear_addr <= clear_addr + A_WIDTH'(1);
          if (clear_addr == ADDR_LAST) begin
            clear_addr    <= '0;
            clear_busy    <= 1'b0;
            clear_pending <= 1'b0;
            rdy_z_buffer  <= 1'b1;
            state         <= IDLE;
          end
        end
        IDLE: begin
          if (transfer_c) begin
            pix_addr     <= pix_in[PIXEL_WIDTH-1 -: A_WIDTH];
            pix_z        <= pix_in[Z_WIDTH-1:0];
            rdy_z_buffer <= 1'b0;
            state        <= READ;
            if (clear_start) begin
              clear_pending <= 1'b1;
            end
          end else if (clear_start || clear_pending) begin
            rdy_z_buffer <= 1'b0;
            clear_busy   <= 1'b1;
            state        <= CLEAR;
          end
        end
        READ: begin
          state <= CMP;
          if (clear_start) begin
            clear_pending <= 1'b1;
          end
        end
        CMP: begin
          if (closer_c) begin
            pass <= 1'b1;
            if (pass_cnt != '1) begin
              pass_cnt <= pass_cnt + CNT_WIDTH'(1);
            end
          end else begin
            fail <= 1'b1;
            if (fail_cnt != '1) begin
              fail_cnt <= fail_cnt + CNT_WIDTH'(1);
            end
          end
          if (clear_pending || clear_start) begin
            clear_pending <= 1'b1;
            clear_busy    <= 1'b1;
            state         <= CLEAR;
          end else begin
            rdy_z_buffer <= 1'b1;
            state        <= IDLE;
          end
        end
        default: begin
          clear_addr   <= '0;
          clear_busy   <= 1'b1;
          rdy_z_buffer <= 1'b0;
          state        <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z_buffer_unit.sv
// Bench for z_buffer_unit: a depth model predicts pass/fail per transfer into
// a scoreboard queue; a monitor logs observed pulses, which are popped and
// matched in order together with their cycle of arrival.
module tb_z_buffer_unit;
  import zbuf_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pix_in = '0;
  logic        send = 1'b0;
  logic        rdy;
  logic        clear_start = 1'b0;
  logic        clear_busy;
  logic        pass;
  logic        fail;
  logic [15:0] pass_cnt;
  logic [15:0] fail_cnt;
  logic [7:0]  disp_addr = '0;
  logic [7:0]  disp_depth;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  typedef struct {
    bit pass;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] model [256];
  int exp_pass = 0;
  int exp_fail = 0;

  logic [1:0] obs_kind [256];
  int         obs_cyc [256];
  int         obs_n = 0;
  int         rd_idx = 0;

  z_buffer_unit dut (
    .clk           (clk),
    .reset         (reset),
    .pix_in        (pix_in),
    .send_z_buffer (send),
    .rdy_z_buffer  (rdy),
    .clear_start   (clear_start),
    .clear_busy    (clear_busy),
    .pass          (pass),
    .fail          (fail),
    .pass_cnt      (pass_cnt),
    .fail_cnt      (fail_cnt),
    .disp_addr     (disp_addr),
    .disp_depth    (disp_depth)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every pass/fail pulse with the cycle it became visible.
  always @(negedge clk) begin
    if (pass || fail) begin
      if (obs_n < 256) begin
        obs_kind[obs_n] <= {pass, fail};
        obs_cyc[obs_n]  <= cyc;
      end
      obs_n <= obs_n + 1;
    end
  end

  // Offer one pixel; pixel data is only placed on the bus once rdy is seen,
  // and with hold set the bus carries a poison pixel while rdy is low.
  task automatic send_pix(input logic [3:0] x, input logic [3:0] y,
                          input logic [7:0] z, input bit hold, input bit clr,
                          output int xfer);
    pixel_t     p;
    exp_t       e;
    int         n;
    logic [7:0] a;
    p.x = x; p.y = y; p.z = z;
    a = {x, y};
    send = 1'b1;
    n = 0;
    while (rdy !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rdy !== 1'b1) begin
      $display("FAIL send_timeout: rdy=%b required 1", rdy);
      send = 1'b0;
      xfer = -1;
    end else begin
      passed++;
      pix_in = p;
      clear_start = clr;
      e.pass = z < model[a];
      e.cyc  = cyc + 3;
      xfer   = cyc + 1;
      exp_q.push_back(e);
      if (e.pass) begin
        model[a] = z;
        exp_pass++;
      end else begin
        exp_fail++;
      end
      @(posedge clk);
      #1;
      clear_start = 1'b0;
      if (hold) pix_in = {8'hAA, 8'h00};
      else send = 1'b0;
      @(negedge clk);
    end
  endtask

  // Pop expected results against logged pulses, in order.
  task automatic sb_drain();
    exp_t e;
    int   n = 0;
    while (exp_q.size() > 0) begin
      if (rd_idx < obs_n) begin
        e = exp_q.pop_front();
        checks++;
        if (obs_kind[rd_idx] !== {e.pass, ~e.pass} || obs_cyc[rd_idx] !== e.cyc)
          $display("FAIL pulse: got pass/fail=%b at cycle %0d, required %b at cycle %0d",
                   obs_kind[rd_idx], obs_cyc[rd_idx], {e.pass, ~e.pass}, e.cyc);
        else passed++;
        rd_idx++;
      end else if (n >= 50) begin
        checks++;
        $display("FAIL pulse_timeout: %0d results missing, required 0", exp_q.size());
        exp_q.delete();
      end else begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (obs_n !== rd_idx) $display("FAIL extra_pulse: got %0d pulses, required %0d", obs_n, rd_idx);
    else passed++;
  endtask

  task automatic test_reset();
    int n = 0;
    int rdy_bad = 0;
    logic [7:0] addrs [3];
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rdy, clear_busy, pass, fail} !== 4'b0100)
      $display("FAIL reset_flags: rdy/busy/pass/fail=%b required 0100", {rdy, clear_busy, pass, fail});
    else passed++;
    checks++;
    if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0)
      $display("FAIL reset_cnt: pass_cnt=%0d fail_cnt=%0d required 0/0", pass_cnt, fail_cnt);
    else passed++;
    reset = 1'b0;
    while (clear_busy === 1'b1 && n < 400) begin
      if (rdy !== 1'b0) rdy_bad++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 256) $display("FAIL clear_len: busy for %0d cycles, required 256", n);
    else passed++;
    checks++;
    if (rdy_bad !== 0 || rdy !== 1'b1)
      $display("FAIL clear_rdy: rdy high %0d times during clear, rdy after=%b, required 0 and 1", rdy_bad, rdy);
    else passed++;
    for (int i = 0; i < 256; i++) model[i] = 8'hFF;
    addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      disp_addr = addrs[i];
      @(negedge clk);
      checks++;
      if (disp_depth !== 8'hFF)
        $display("FAIL init_depth[%h]: got %h required ff", addrs[i], disp_depth);
      else passed++;
    end
  endtask

  task automatic test_single();
    int t;
    send_pix(4'd3, 4'd5, 8'h40, 1'b0, 1'b0, t);
    checks++;
    if (rdy !== 1'b0) $display("FAIL rdy_t0: got %b required 0", rdy);
    else passed++;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b0) $display("FAIL rdy_t1: got %b required 0", rdy);
    else passed++;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1 || pass !== 1'b1)
      $display("FAIL rdy_pass_t2: rdy=%b pass=%b required 1 1", rdy, pass);
    else passed++;
    sb_drain();
    checks++;
    if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0)
      $display("FAIL single_cnt: pass_cnt=%0d fail_cnt=%0d required 1/0", pass_cnt, fail_cnt);
    else passed++;
    disp_addr = 8'h35;
    @(negedge clk);
    checks++;
    if (disp_depth !== 8'h40) $display("FAIL single_depth: got %h required 40", disp_depth);
    else passed++;
  endtask

  task automatic test_depth_sequence();
    int t;
    send_pix(4'd3, 4'd5, 8'h50, 1'b0, 1'b0, t);
    send_pix(4'd3, 4'd5, 8'h40, 1'b0, 1'b0, t);
    send_pix(4'd3, 4'd5, 8'h10, 1'b0, 1'b0, t);
    sb_drain();
    checks++;
    if (pass_cnt !== 16'd2 || fail_cnt !== 16'd2)
      $display("FAIL seq_cnt: pass_cnt=%0d fail_cnt=%0d required 2/2", pass_cnt, fail_cnt);
    else passed++;
    disp_addr = 8'h35;
    @(negedge clk);
    checks++;
    if (disp_depth !== 8'h10) $display("FAIL seq_depth: got %h required 10", disp_depth);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int         t [4];
    logic [7:0] addrs [4];
    logic [7:0] want [4];
    send_pix(4'd0, 4'd0, 8'h80, 1'b1, 1'b0, t[0]);
    send_pix(4'd0, 4'd0, 8'h90, 1'b1, 1'b0, t[1]);
    send_pix(4'd7, 4'd7, 8'h01, 1'b1, 1'b0, t[2]);
    send_pix(4'hF, 4'hF, 8'hFE, 1'b1, 1'b0, t[3]);
    send = 1'b0;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (t[i] - t[i-1] !== 3)
        $display("FAIL b2b_spacing[%0d]: got %0d cycles required 3", i, t[i] - t[i-1]);
      else passed++;
    end
    sb_drain();
    addrs[0] = 8'h00; want[0] = 8'h80;
    addrs[1] = 8'h77; want[1] = 8'h01;
    addrs[2] = 8'hFF; want[2] = 8'hFE;
    addrs[3] = 8'hAA; want[3] = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      disp_addr = addrs[i];
      @(negedge clk);
      checks++;
      if (disp_depth !== want[i])
        $display("FAIL b2b_depth[%h]: got %h required %h", addrs[i], disp_depth, want[i]);
      else passed++;
    end
    checks++;
    if (pass_cnt !== 16'd5 || fail_cnt !== 16'd3)
      $display("FAIL b2b_cnt: pass_cnt=%0d fail_cnt=%0d required 5/3", pass_cnt, fail_cnt);
    else passed++;
  endtask

  task automatic test_clear_coincident();
    int t;
    int n = 0;
    send_pix(4'd1, 4'd1, 8'h20, 1'b0, 1'b1, t);
    @(negedge clk);
    disp_addr = 8'h11;
    @(negedge clk);
    checks++;
    if (clear_busy !== 1'b1 || rdy !== 1'b0)
      $display("FAIL cc_enter: busy=%b rdy=%b required 1 0", clear_busy, rdy);
    else passed++;
    checks++;
    if (disp_depth !== 8'hFF) $display("FAIL cc_collision: got %h required ff", disp_depth);
    else passed++;
    while (clear_busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checks++;
        if (disp_depth !== 8'h20) $display("FAIL cc_written: got %h required 20", disp_depth);
        else passed++;
      end
    end
    checks++;
    if (n !== 256 || rdy !== 1'b1)
      $display("FAIL cc_clear_len: busy for %0d cycles rdy=%b, required 256 and 1", n, rdy);
    else passed++;
    checks++;
    if (disp_depth !== 8'hFF) $display("FAIL cc_cleared: got %h required ff", disp_depth);
    else passed++;
    for (int i = 0; i < 256; i++) model[i] = 8'hFF;
    sb_drain();
    checks++;
    if (pass_cnt !== 16'd6 || fail_cnt !== 16'd3)
      $display("FAIL cc_cnt: pass_cnt=%0d fail_cnt=%0d required 6/3", pass_cnt, fail_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int t;
    int n = 0;
    int snap;
    snap = obs_n;
    send_pix(4'd2, 4'd2, 8'h30, 1'b0, 1'b0, t);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy, clear_busy, pass, fail} !== 4'b0100)
      $display("FAIL rm_flags: rdy/busy/pass/fail=%b required 0100", {rdy, clear_busy, pass, fail});
    else passed++;
    checks++;
    if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0)
      $display("FAIL rm_cnt: pass_cnt=%0d fail_cnt=%0d required 0/0", pass_cnt, fail_cnt);
    else passed++;
    reset = 1'b0;
    while (clear_busy === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 256) $display("FAIL rm_clear_len: busy for %0d cycles, required 256", n);
    else passed++;
    checks++;
    if (obs_n !== snap) $display("FAIL rm_pulse: got %0d pulses, required %0d", obs_n, snap);
    else passed++;
    exp_q.delete();
    rd_idx = obs_n;
    exp_pass = 0;
    exp_fail = 0;
    for (int i = 0; i < 256; i++) model[i] = 8'hFF;
    disp_addr = 8'h22;
    @(negedge clk);
    checks++;
    if (disp_depth !== 8'hFF) $display("FAIL rm_depth: got %h required ff", disp_depth);
    else passed++;
    send_pix(4'd2, 4'd2, 8'h30, 1'b0, 1'b0, t);
    sb_drain();
    checks++;
    if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0)
      $display("FAIL rm_resume_cnt: pass_cnt=%0d fail_cnt=%0d required 1/0", pass_cnt, fail_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_depth_sequence();
    test_back_to_back();
    test_clear_coincident();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
